// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// Asynchronous serial receiver. Deserialises 8N1 frames (8E1 when the
// PARITY_EN macro is defined) into bytes for the display-control decoder.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 16)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   uart_rx        serial line, idle high, asynchronous to clk
//   rx_data_valid  one-clock strobe, rx_data_out holds a new good byte
//   rx_data_out    last good byte, held between frames
//   rx_frame_err   one-clock strobe, bad stop bit (or bad parity)
//   rx_busy        high while a frame is in progress
//
// Build option:
//   PARITY_EN  defined -> even parity bit checked after the data bits
// -----------------------------------------------------------------------------
module uart_byte_rx #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_data_valid,
    output logic [7:0] rx_data_out,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = $clog2(BPS_CNT);
    // START samples half a bit after the detected edge; every later state
    // samples one full bit after the previous sample, so all land mid-bit.
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(BPS_CNT - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;
`endif

    // Even parity: XOR of data and parity bit must be zero.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ((^data) ^ par) == 1'b0;
    endfunction

    logic             rx_sync1_r;
    logic             rx_sync2_r;
    logic             rx_sync3_r;
    logic             rx_line_s;
    logic             fall_s;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_next_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next_s;
    logic [7:0]       data_out_next_s;
    logic             valid_next_s;
    logic             err_next_s;
    logic             parity_ok_s;
    logic             mid_hit_s;
    logic             bit_hit_s;
`ifdef PARITY_EN
    logic             par_r;
    logic             par_next_s;
`endif

    assign rx_line_s = rx_sync2_r;
    assign fall_s    = rx_sync3_r & ~rx_sync2_r;
    assign mid_hit_s = (cnt_r == MID_CNT);
    assign bit_hit_s = (cnt_r == END_CNT);

`ifdef PARITY_EN
    assign parity_ok_s = even_parity_ok(shift_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_sync3_r <= 1'b1;
        end else begin
            rx_sync1_r <= uart_rx;
            rx_sync2_r <= rx_sync1_r;
            rx_sync3_r <= rx_sync2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_next_s    = state_r;
        bit_idx_next_s  = bit_idx_r;
        shift_next_s    = shift_r;
        data_out_next_s = rx_data_out;
        valid_next_s    = 1'b0;
        err_next_s      = 1'b0;
`ifdef PARITY_EN
        par_next_s      = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (mid_hit_s) begin
                    bit_idx_next_s = 3'd0;
                    if (!rx_line_s) begin
                        state_next_s = DATA;
                    end else begin
                        // Line back high at mid-start: glitch, not a frame.
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_hit_s) begin
                    shift_next_s = {rx_line_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_next_s = 3'd0;
`ifdef PARITY_EN
                        state_next_s   = PARITY;
`else
                        state_next_s   = STOP;
`endif
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_hit_s) begin
                    par_next_s   = rx_line_s;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_hit_s) begin
                    if (rx_line_s && parity_ok_s) begin
                        // Byte lands one clock ahead of the valid strobe.
                        data_out_next_s = shift_r;
                        state_next_s    = DONE;
                    end else begin
                        err_next_s   = 1'b1;
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            DONE: begin
                valid_next_s = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        // Counter restarts on every state change and at each full bit.
        if ((state_next_s != state_r) || (state_r == IDLE) || bit_hit_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= {CNT_W{1'b0}};
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            rx_data_out   <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_busy       <= 1'b0;
`ifdef PARITY_EN
            par_r         <= 1'b0;
`endif
        end else begin
            cnt_r         <= cnt_next_s;
            bit_idx_r     <= bit_idx_next_s;
            shift_r       <= shift_next_s;
            rx_data_out   <= data_out_next_s;
            rx_data_valid <= valid_next_s;
            rx_frame_err  <= err_next_s;
            rx_busy       <= (state_next_s != IDLE);
`ifdef PARITY_EN
            par_r         <= par_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_rx
// Directed bench for uart_byte_rx. The receiver runs at 64 clocks per bit so
// the full scenario list stays short; the glitch is scaled to stay well under
// half a bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int CLK_FREQ  = 12_000_000;
    localparam int BAUD_RATE = 187_500;
    localparam int BPS       = CLK_FREQ / BAUD_RATE;   // 64
    localparam int GLITCH    = 20;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic       rx_data_valid;
    logic [7:0] rx_data_out;
    logic       rx_frame_err;
    logic       rx_busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Monitor state
    int         cyc        = 0;
    int         valid_cnt  = 0;
    int         err_cnt    = 0;
    int         rise_cyc   = 0;
    int         start_cyc  = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    bit         both_high  = 1'b0;
    bit         valid_long = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] pre_q[$];

    uart_byte_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .rx_data_valid (rx_data_valid),
        .rx_data_out   (rx_data_out),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_data_valid) begin
            valid_cnt = valid_cnt + 1;
            if (!valid_prev) begin
                rx_q.push_back(rx_data_out);
                pre_q.push_back(data_prev);
                rise_cyc = cyc;
            end else begin
                valid_long = 1'b1;
            end
        end
        if (rx_frame_err) err_cnt = err_cnt + 1;
        if (rx_frame_err && rx_data_valid) both_high = 1'b1;
        data_prev  = rx_data_out;
        valid_prev = rx_data_valid;
    end

    task automatic clear_mon();
        valid_cnt = 0;
        err_cnt   = 0;
        rx_q.delete();
        pre_q.delete();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        uart_rx = b;
        repeat (BPS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) send_bit(1'b1);   // never true: parity unused in 8N1
`endif
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (n * BPS) @(negedge clk);
    endtask

    task automatic check_outputs_reset(input string tag);
        chk_cnt++;
        if (rx_data_valid !== 1'b0) $display("FAIL %s valid: got %b want 0", tag, rx_data_valid);
        else pass_cnt++;
        chk_cnt++;
        if (rx_data_out !== 8'h00) $display("FAIL %s data_out: got %h want 00", tag, rx_data_out);
        else pass_cnt++;
        chk_cnt++;
        if (rx_frame_err !== 1'b0) $display("FAIL %s frame_err: got %b want 0", tag, rx_frame_err);
        else pass_cnt++;
        chk_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, rx_busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int lat;
        clear_mon();
        send_frame(8'h35, 1'b0, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 1) $display("FAIL single valid_count: got %0d want 1", valid_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h35) $display("FAIL single data: got %h want 35", rx_data_out);
        else pass_cnt++;
        chk_cnt++;
        if (pre_q.size() != 1 || pre_q[0] !== 8'h35) $display("FAIL single data_before_valid: got %h want 35", (pre_q.size() > 0) ? pre_q[0] : 8'hxx);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 0) $display("FAIL single frame_err_count: got %0d want 0", err_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL single busy_after: got %b want 0", rx_busy);
        else pass_cnt++;
        // 3 sync clocks + 9.5 bits + 2 clocks, with a few clocks of slack
        lat = rise_cyc - start_cyc;
        chk_cnt++;
        if (lat < 9 * BPS + BPS / 2 - 5 || lat > 9 * BPS + BPS / 2 + 8)
            $display("FAIL single latency: got %0d want about %0d", lat, 9 * BPS + BPS / 2 + 5);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h31, 1'b1, 1'b1);
        send_frame(8'h32, 1'b1, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 2) $display("FAIL b2b valid_count: got %0d want 2", valid_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() < 1 || rx_q[0] !== 8'h31) $display("FAIL b2b first: got %h want 31", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() < 2 || rx_q[1] !== 8'h32) $display("FAIL b2b second: got %h want 32", (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 0) $display("FAIL b2b frame_err_count: got %0d want 0", err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (GLITCH) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BPS) @(negedge clk);
        chk_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL glitch busy: got %b want 0", rx_busy);
        else pass_cnt++;
        chk_cnt++;
        if (valid_cnt !== 0 || err_cnt !== 0) $display("FAIL glitch strobes: got valid %0d err %0d want 0 0", valid_cnt, err_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_data_out !== 8'h32) $display("FAIL glitch data_held: got %h want 32", rx_data_out);
        else pass_cnt++;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 1 || rx_data_out !== 8'hA5) $display("FAIL glitch next_byte: got %h (%0d valids) want a5", rx_data_out, valid_cnt);
        else pass_cnt++;
    endtask

    task automatic test_framing_error();
        clear_mon();
        send_frame(8'h37, 1'b1, 1'b0);
        idle_bits(2);
        chk_cnt++;
        if (err_cnt !== 1) $display("FAIL framing err_count: got %0d want 1", err_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (valid_cnt !== 0) $display("FAIL framing valid_count: got %0d want 0", valid_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_data_out !== 8'hA5) $display("FAIL framing data_held: got %h want a5", rx_data_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        repeat (BPS / 2) @(negedge clk);
        chk_cnt++;
        if (rx_busy !== 1'b1) $display("FAIL midreset busy_before: got %b want 1", rx_busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        check_outputs_reset("midreset");
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        rst_n   = 1'b1;
        repeat (2 * BPS) @(negedge clk);
        chk_cnt++;
        if (valid_cnt !== 0 || err_cnt !== 0) $display("FAIL midreset strobes: got valid %0d err %0d want 0 0", valid_cnt, err_cnt);
        else pass_cnt++;
        send_frame(8'h39, 1'b0, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 1 || rx_data_out !== 8'h39) $display("FAIL midreset next_byte: got %h (%0d valids) want 39", rx_data_out, valid_cnt);
        else pass_cnt++;
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h03, 1'b0, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 1 || err_cnt !== 0 || rx_data_out !== 8'h03)
            $display("FAIL parity_good: got %h valid %0d err %0d want 03 1 0", rx_data_out, valid_cnt, err_cnt);
        else pass_cnt++;
        clear_mon();
        send_frame(8'h03, 1'b1, 1'b1);
        idle_bits(1);
        chk_cnt++;
        if (valid_cnt !== 0 || err_cnt !== 1)
            $display("FAIL parity_bad: got valid %0d err %0d want 0 1", valid_cnt, err_cnt);
        else pass_cnt++;
    endtask
`endif

    task automatic test_strobe_rules();
        chk_cnt++;
        if (both_high !== 1'b0) $display("FAIL strobe_exclusive: got %b want 0", both_high);
        else pass_cnt++;
        chk_cnt++;
        if (valid_long !== 1'b0) $display("FAIL valid_width: got multi-cycle %b want 0", valid_long);
        else pass_cnt++;
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
`ifdef PARITY_EN
        test_parity();
`endif
        test_strobe_rules();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Asynchronous serial receiver that deserialises 8N1 frames (8E1 when parity is compiled in) from the board's UART pin into bytes. It sits directly upstream of the display-control decoder. It produces the one-clock `rx_data_valid` strobe and the `rx_data_out` byte that the decoder shifts into the 8-digit seven-segment data.

## Interface
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `BPS_CNT` is a derived localparam equal to CLK_FREQ/BAUD_RATE, integer division (1250 at defaults). It must be ≥ 16.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data_valid`  out  1  one-clock strobe: a good byte is available.
- `rx_data_out`  out  8  last good byte; held between frames.
- `rx_frame_err`  out  1  one-clock strobe: bad stop bit, or bad parity when PARITY_EN is compiled in.
- `rx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input synchroniser**
  - `uart_rx` passes through a 2-flop synchroniser, then a third flop for edge detection.
  - All flops reset to 1.
  - A falling edge on the synchronised line in IDLE starts a frame.
- **Baud counter**
  - `cnt` counts 0..BPS_CNT-1 while not IDLE and clears on every state change.
  - The sample point is `cnt == BPS_CNT/2 - 1`, i.e. mid-bit.
  - `bit_idx` is 0..7.
- **States:** IDLE, START, DATA, PARITY (present only with PARITY_EN), STOP, DONE.
  - **IDLE → START** on falling edge.
  - **START**
    - Sample at the mid-start point.
    - If the line is 0: go to DATA and reset `cnt` so later samples land mid-bit.
    - If the line is 1: false start, return to IDLE with no strobes.
  - **DATA**
    - At each mid-bit sample, shift the line into the shift register, LSB first.
    - After `bit_idx` 7, go to PARITY (if compiled) or STOP.
  - **PARITY:** sample the parity bit at mid-bit and go to STOP.
  - **STOP:** sample at mid-bit.
    - If the line is 1 and parity is OK: load `rx_data_out` from the shift register, then go to DONE.
    - Otherwise: pulse `rx_frame_err` for one clock, leave `rx_data_out` unchanged, and go to IDLE.
  - **DONE:** assert `rx_data_valid` for exactly one clock, then go to IDLE.
- **Ordering guarantee.** `rx_data_out` changes one clock before `rx_data_valid` rises and is stable while it is high. The downstream decoder clocks on the `rx_data_valid` edge and depends on this.
- **Back-to-back frames.** The FSM returns to IDLE at mid-stop plus 1–2 clocks. A start edge arriving in the second half of the stop bit is caught.
- **Line held low in IDLE.** A continuous low (break) produces no new edge. Nothing happens until the line returns high and falls again.
- **Reset mid-frame.**
  - All state is cleared immediately.
  - The partial byte is discarded.
  - No strobe is generated.

## Timing
- **Reset values:**
  - `rx_data_valid` = 0
  - `rx_data_out` = 8'h00
  - `rx_frame_err` = 0
  - `rx_busy` = 0
  - state = IDLE
  - shift register = 0, `cnt` = 0, `bit_idx` = 0
- **Latency.** Measured from the pin's falling edge (start bit) to the `rx_data_valid` rising edge:
  - without parity: 3 sync clocks + 9.5 bit periods + 2 clocks;
  - with parity: add 1 bit period.
- **Sample error.** Mid-bit sampling tolerates about ±4% baud mismatch over the frame.
- **Outputs.** All outputs are registered; there are no combinational paths from `uart_rx`.
- **Strobe exclusivity.** `rx_data_valid` and `rx_frame_err` are never high in the same clock.

## Configuration
- **PARITY_EN**
  - Defined: frames are 8E1. The even-parity bit is checked in the PARITY state. The XOR of the 8 data bits and the parity bit must be 0; otherwise `rx_frame_err` pulses at the STOP sample and no valid strobe is produced.
  - Undefined: frames are 8N1. The PARITY state and its logic are absent, and `rx_frame_err` reports stop-bit errors only.

## Test plan
- **Single byte.** Send 8'h35 ('5') at 9600 baud, 12 MHz clock, default parameters. Expect `rx_data_out` = 8'h35 one clock before a single one-clock `rx_data_valid` pulse, no `rx_frame_err`, and `rx_busy` low afterwards.
- **Back-to-back bytes.** Send 8'h31 then 8'h32 with zero idle between frames. Expect two valid pulses with `rx_data_out` = 8'h31 then 8'h32, and no errors.
- **Glitch rejection.** Drive a 400-clock low pulse (shorter than half a bit) in IDLE. Expect return to IDLE with no strobes, `rx_data_out` unchanged, and a subsequent 8'hA5 received correctly.
- **Framing error.** Send 8'h37 with the stop bit forced to 0. Expect one `rx_frame_err` pulse, no `rx_data_valid`, and `rx_data_out` keeping its previous value.
- **Reset mid-frame.** Assert `rst_n` low during data bit 4 of 8'hFF. Expect all outputs at reset values immediately; the next frame 8'h39 is received correctly.
- **Parity (PARITY_EN defined).**
  - Send 8'h03 with parity bit 0: valid pulse, `rx_data_out` = 8'h03.
  - Send 8'h03 with parity bit 1: `rx_frame_err` pulse, no valid.
